sc_fifo_param: RTL and testbench

Single-clock FIFO: next generation of the JPEG encoder's byte FIFO, generalised in data width and depth. Adds runtime-programmable almost-full/almost-empty thresholds, a read-data-valid strobe, guarded pointer/count updates and sticky overflow/underflow flags. Used between the camera capture path, the encoder pipeline stages and the bitstream output packer.

---
 rtl/sc_fifo_pkg.sv | 19 +
 rtl/sc_fifo_ram.sv | 35 +++
 rtl/sc_fifo_param.sv | 131 +++++++++++++
 tb/tb_sc_fifo_param.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_fifo_pkg.sv
// Shared defaults and width helpers for the parameterised single-clock FIFO.
package sc_fifo_pkg;

    localparam int SC_FIFO_DEFAULT_DATA_WIDTH = 8;
    localparam int SC_FIFO_DEFAULT_DEPTH      = 512;

    // Smallest n with 2**n >= value; usable in constant expressions.
    function automatic int sc_fifo_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
// Kept separate so a vendor block-RAM primitive can replace it later.
module sc_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512,
    parameter int AW         = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array itself is never cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sc_fifo_param.sv
// Single-clock FIFO with programmable almost flags and sticky overflow/underflow.
// Define SC_FIFO_FWFT_EN for first-word-fall-through; default is registered read.
module sc_fifo_param
    import sc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SC_FIFO_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = SC_FIFO_DEFAULT_DEPTH,
    localparam int AW        = sc_fifo_log2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [CW-1:0]         cnt,
    output logic                  overflow,
    output logic                  underflow
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          valid_q;
    logic          ovf_q;
    logic          unf_q;
    logic          wr_ok;
    logic          rd_ok;
    logic          ram_re;
    logic          over_hit;
    logic          under_hit;
    logic          valid_next;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);
    assign cnt          = count;
    assign data_valid   = valid_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Handshake: write is accepted on an edge when ~full & ~clear; read is
    // accepted when a word is available (~empty, or data_valid in FWFT) & ~clear.
    // Rejected requests are dropped and only raise the sticky flags.
    always_comb begin
        wr_ok    = write & ~full & ~clear;
        over_hit = write & full & ~clear;
`ifdef SC_FIFO_FWFT_EN
        rd_ok      = read & valid_q & ~clear;
        under_hit  = read & ~valid_q & ~clear;
        // Prefetch from RAM whenever it holds words and the output slot frees up.
        ram_re     = ((count - CW'(valid_q)) != '0) & (~valid_q | rd_ok) & ~clear;
        valid_next = valid_q;
        if (clear) begin
            valid_next = 1'b0;
        end else if (ram_re) begin
            valid_next = 1'b1;
        end else if (rd_ok) begin
            valid_next = 1'b0;
        end
`else
        rd_ok      = read & ~empty & ~clear;
        under_hit  = read & empty & ~clear;
        ram_re     = rd_ok;
        valid_next = rd_ok;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
            valid_q <= valid_next;
            if (over_hit) begin
                ovf_q <= 1'b1;
            end
            if (under_hit) begin
                unf_q <= 1'b1;
            end
        end
    end

    sc_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (wr_ok),
        .waddr(wr_ptr),
        .wdata(data_in),
        .re   (ram_re),
        .raddr(rd_ptr),
        .rdata(data_out)
    );

endmodule

// File: tb/tb_sc_fifo_param.sv
// Self-checking bench for sc_fifo_param (DEPTH=16), queue-based reference model.
`timescale 1ns/1ps
module tb_sc_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          write;
    logic [DW-1:0] data_in;
    logic          read;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;
    logic          full;
    logic          almost_full;
    logic          empty;
    logic          almost_empty;
    logic [CW-1:0] cnt;
    logic          overflow;
    logic          underflow;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: exp_q holds every unconsumed word in arrival order.
    logic [DW-1:0] exp_q[$];
    logic          m_dv;
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_unf;

    typedef struct {
        logic          c;
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        int            e_cnt;
        logic          e_dv;
        logic [DW-1:0] e_dout;
        logic          e_empty;
        logic          e_unf;
    } vec_t;
    vec_t tbl[6];

    sc_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .write       (write),
        .data_in     (data_in),
        .read        (read),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .af_thresh   (af_thresh),
        .ae_thresh   (ae_thresh),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .almost_empty(almost_empty),
        .cnt         (cnt),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_dv   = 1'b0;
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_edge(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
        bit wr_acc;
        if (c) begin
            exp_q.delete();
            m_dv  = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wr_acc = w && (exp_q.size() < DEPTH);
            if (w && exp_q.size() == DEPTH) m_ovf = 1'b1;
`ifdef SC_FIFO_FWFT_EN
            if (r && !m_dv) m_unf = 1'b1;
            if (r && m_dv) void'(exp_q.pop_front());
            // A word already stored before this edge becomes visible after it.
            m_dv = (exp_q.size() > 0);
            if (m_dv) m_dout = exp_q[0];
`else
            if (r && exp_q.size() == 0) m_unf = 1'b1;
            if (r && exp_q.size() > 0) begin
                m_dout = exp_q.pop_front();
                m_dv   = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
`endif
            if (wr_acc) exp_q.push_back(d);
        end
    endtask

    task automatic compare_all();
        check("cnt",          32'(cnt),          32'(exp_q.size()));
        check("full",         32'(full),         32'(exp_q.size() == DEPTH));
        check("empty",        32'(empty),        32'(exp_q.size() == 0));
        check("almost_full",  32'(almost_full),  32'(exp_q.size() >= int'(af_thresh)));
        check("almost_empty", 32'(almost_empty), 32'(exp_q.size() <= int'(ae_thresh)));
        check("data_valid",   32'(data_valid),   32'(m_dv));
        check("data_out",     32'(data_out),     32'(m_dout));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_unf));
    endtask

    task automatic step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
        clear   = c;
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clk);
        model_edge(c, w, r, d);
        #1;
        compare_all();
    endtask

    initial begin
        int wp;
        int rp;
        reset     = 1'b1;
        clear     = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        data_in   = '0;
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #2 reset = 1'b0;

        // Table of short hand-derived sequences from reset.
`ifdef SC_FIFO_FWFT_EN
        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h3C, 1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h3C, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h3C, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h3C, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h3C, 1'b1, 1'b0};
`else
        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'hA5, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'hA5, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
            check("tbl_cnt",   32'(cnt),        32'(tbl[i].e_cnt));
            check("tbl_dv",    32'(data_valid), 32'(tbl[i].e_dv));
            check("tbl_dout",  32'(data_out),   32'(tbl[i].e_dout));
            check("tbl_empty", 32'(empty),      32'(tbl[i].e_empty));
            check("tbl_unf",   32'(underflow),  32'(tbl[i].e_unf));
        end

        // Fill to full, one extra write, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        check("fill_full", 32'(full),     32'd1);
        check("fill_cnt",  32'(cnt),      32'd16);
        check("fill_ovf",  32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
`ifdef SC_FIFO_FWFT_EN
            check("drain_head", 32'(data_out), 32'(i));
            step(1'b0, 1'b0, 1'b1, 8'h00);
`else
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("drain_data", 32'(data_out), 32'(i));
`endif
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("drain_empty",   32'(empty),    32'd1);
        check("drain_ovf_hold", 32'(overflow), 32'd1);

        // Steady state at cnt=5 with simultaneous read/write across the wrap.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(8'h40 + i));
            check("rw_cnt5", 32'(cnt), 32'd5);
        end

        // Threshold crossings while filling and draining.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        check("af_at13", 32'(almost_full), 32'd1);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        check("ae_drained", 32'(almost_empty), 32'd1);

        // Clear with overflow set at cnt=7, colliding with write and read.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        check("pre_clr_cnt", 32'(cnt),      32'd7);
        check("pre_clr_ovf", 32'(overflow), 32'd1);
        step(1'b1, 1'b1, 1'b1, 8'hEE);
        check("clr_cnt",   32'(cnt),        32'd0);
        check("clr_empty", 32'(empty),      32'd1);
        check("clr_ovf",   32'(overflow),   32'd0);
        check("clr_unf",   32'(underflow),  32'd0);
        check("clr_dv",    32'(data_valid), 32'd0);

        // Thresholds act combinationally between edges.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        clear     = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        af_thresh = 5'd0;
        ae_thresh = 5'd16;
        #1;
        check("af_zero",  32'(almost_full),  32'd1);
        check("ae_depth", 32'(almost_empty), 32'd1);
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        #1;
        check("af_back", 32'(almost_full),  32'd0);
        check("ae_back", 32'(almost_empty), 32'd1);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h30 + i));
        write   = 1'b1;
        data_in = 8'h77;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_cnt",   32'(cnt),        32'd0);
        check("rst_empty", 32'(empty),      32'd1);
        check("rst_dv",    32'(data_valid), 32'd0);
        check("rst_dout",  32'(data_out),   32'd0);
        compare_all();
        #1 reset = 1'b0;
        write = 1'b0;

        // Randomised traffic against the model.
        wp = 50;
        rp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                wp = $urandom_range(10, 90);
                rp = $urandom_range(10, 90);
            end
            if (i % 97 == 0) begin
                af_thresh = CW'($urandom_range(0, 31));
                ae_thresh = CW'($urandom_range(0, 31));
            end
            step($urandom_range(0, 127) == 0,
                 $urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < rp,
                 DW'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
